// File: rtl/m_axi_dma_cfg_write_pkg.sv
// Shared definitions for the DMA configuration write engine: register map,
// control word, AXI response code and state encodings.
package m_axi_dma_cfg_write_pkg;

   // DMA register offsets, relative to the DMA base address
   localparam logic [7:0] MM2S_DMACR_OFF  = 8'h00;
   localparam logic [7:0] S2MM_DMACR_OFF  = 8'h30;
   localparam logic [7:0] MM2S_SA_OFF     = 8'h18;
   localparam logic [7:0] S2MM_DA_OFF     = 8'h48;
   localparam logic [7:0] S2MM_LENGTH_OFF = 8'h58;
   localparam logic [7:0] MM2S_LENGTH_OFF = 8'h28;

   // Control register value that sets the run/stop bit
   localparam logic [31:0] DMACR_RUN = 32'h0000_0001;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   // Index of the final register write in the programming sequence
   localparam logic [2:0] LAST_STEP = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR_DATA,
      S_RESP,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      BEAT_IDLE,
      BEAT_REQ,
      BEAT_RESP
   } beat_state_t;

endpackage

// File: rtl/m_axi_dma_cfg_write_axil_wr_beat.sv
// One AXI4-Lite single-beat write: raises AW and W together, lets each drop on
// its own handshake, then waits for the B response.
module axil_wr_beat #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic [DATA_WIDTH-1:0]   data,
   output logic                    req_done,
   output logic                    done,
   output logic [1:0]              resp,
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    wvalid,
   input  logic                    wready,
   input  logic [1:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready
);
   import m_axi_dma_cfg_write_pkg::*;

   beat_state_t phase;
   logic        aw_ok;
   logic        w_ok;

   // A channel counts as finished once its valid is low or is being accepted now
   assign aw_ok    = ~awvalid | awready;
   assign w_ok     = ~wvalid | wready;
   assign req_done = (phase == BEAT_REQ) & aw_ok & w_ok;
   assign done     = (phase == BEAT_RESP) & bvalid;
   assign resp     = bresp;
   assign wstrb    = '1;

   // Request/response sequencing; address and data are frozen while their valid is high
   always_ff @(posedge clk) begin
      if (reset) begin
         phase   <= BEAT_IDLE;
         awvalid <= 1'b0;
         wvalid  <= 1'b0;
         bready  <= 1'b0;
         awaddr  <= '0;
         wdata   <= '0;
      end else begin
         case (phase)
            BEAT_IDLE: begin
               if (start) begin
                  awaddr  <= addr;
                  wdata   <= data;
                  awvalid <= 1'b1;
                  wvalid  <= 1'b1;
                  phase   <= BEAT_REQ;
               end
            end
            BEAT_REQ: begin
               if (awvalid && awready) begin
                  awvalid <= 1'b0;
               end
               if (wvalid && wready) begin
                  wvalid <= 1'b0;
               end
               if (req_done) begin
                  bready <= 1'b1;
                  phase  <= BEAT_RESP;
               end
            end
            BEAT_RESP: begin
               if (bvalid) begin
                  bready <= 1'b0;
                  phase  <= BEAT_IDLE;
               end
            end
            default: begin
               phase <= BEAT_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/m_axi_dma_cfg_write.sv
// DMA configuration write engine: latches one transfer descriptor and programs
// the DMA with six register writes, S2MM armed before MM2S, then pulses done/err.
module m_axi_dma_cfg_write #(
   parameter int                         GLOB_ADDR_WIDTH      = 32,
   parameter int                         GLOB_DATA_WIDTH      = 32,
   parameter int                         BANK1_SRC_ADDR_WIDTH = 32,
   parameter int                         BANK1_SRC_SIZE_WIDTH = 26,
   parameter int                         BANK1_DST_ADDR_WIDTH = 32,
   parameter int                         BANK1_DST_SIZE_WIDTH = 26,
   parameter logic [GLOB_ADDR_WIDTH-1:0] DMA_BASE_ADDR        = '0
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic [BANK1_SRC_ADDR_WIDTH-1:0] cmd_src_addr,
   input  logic [BANK1_SRC_SIZE_WIDTH-1:0] cmd_src_size,
   input  logic [BANK1_DST_ADDR_WIDTH-1:0] cmd_dst_addr,
   input  logic [BANK1_DST_SIZE_WIDTH-1:0] cmd_dst_size,
   output logic                            done,
   output logic                            err,
   output logic [GLOB_ADDR_WIDTH-1:0]      M_AXI_AWADDR,
   output logic                            M_AXI_AWVALID,
   input  logic                            M_AXI_AWREADY,
   output logic [GLOB_DATA_WIDTH-1:0]      M_AXI_WDATA,
   output logic [GLOB_DATA_WIDTH/8-1:0]    M_AXI_WSTRB,
   output logic                            M_AXI_WVALID,
   input  logic                            M_AXI_WREADY,
   input  logic [1:0]                      M_AXI_BRESP,
   input  logic                            M_AXI_BVALID,
   output logic                            M_AXI_BREADY
);
   import m_axi_dma_cfg_write_pkg::*;

   state_t                          state;
   logic [2:0]                      step;
   logic                            beat_start;
   logic                            beat_req_done;
   logic                            beat_done;
   logic [1:0]                      beat_resp;
   logic [BANK1_SRC_ADDR_WIDTH-1:0] src_addr_q;
   logic [BANK1_SRC_SIZE_WIDTH-1:0] src_size_q;
   logic [BANK1_DST_ADDR_WIDTH-1:0] dst_addr_q;
   logic [BANK1_DST_SIZE_WIDTH-1:0] dst_size_q;
   logic [7:0]                      wr_offset;
   logic [GLOB_DATA_WIDTH-1:0]      wr_data;
   logic [GLOB_ADDR_WIDTH-1:0]      wr_addr;

   // Register map walk: control words first, then addresses, then S2MM length before MM2S length
   always_comb begin
      wr_offset = MM2S_DMACR_OFF;
      wr_data   = GLOB_DATA_WIDTH'(DMACR_RUN);
      case (step)
         3'd0: begin
            wr_offset = MM2S_DMACR_OFF;
            wr_data   = GLOB_DATA_WIDTH'(DMACR_RUN);
         end
         3'd1: begin
            wr_offset = S2MM_DMACR_OFF;
            wr_data   = GLOB_DATA_WIDTH'(DMACR_RUN);
         end
         3'd2: begin
            wr_offset = MM2S_SA_OFF;
            wr_data   = GLOB_DATA_WIDTH'(src_addr_q);
         end
         3'd3: begin
            wr_offset = S2MM_DA_OFF;
            wr_data   = GLOB_DATA_WIDTH'(dst_addr_q);
         end
         3'd4: begin
            wr_offset = S2MM_LENGTH_OFF;
            wr_data   = GLOB_DATA_WIDTH'(dst_size_q);
         end
         3'd5: begin
            wr_offset = MM2S_LENGTH_OFF;
            wr_data   = GLOB_DATA_WIDTH'(src_size_q);
         end
         default: begin
            wr_offset = MM2S_DMACR_OFF;
            wr_data   = GLOB_DATA_WIDTH'(DMACR_RUN);
         end
      endcase
   end

   assign wr_addr = DMA_BASE_ADDR + GLOB_ADDR_WIDTH'(wr_offset);

   // Descriptor sequencer; a zero-length descriptor is rejected without touching the bus
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         step       <= 3'd0;
         cmd_ready  <= 1'b1;
         done       <= 1'b0;
         err        <= 1'b0;
         beat_start <= 1'b0;
         src_addr_q <= '0;
         src_size_q <= '0;
         dst_addr_q <= '0;
         dst_size_q <= '0;
      end else begin
         done       <= 1'b0;
         err        <= 1'b0;
         beat_start <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  src_addr_q <= cmd_src_addr;
                  src_size_q <= cmd_src_size;
                  dst_addr_q <= cmd_dst_addr;
                  dst_size_q <= cmd_dst_size;
                  step       <= 3'd0;
                  cmd_ready  <= 1'b0;
                  if ((cmd_src_size == '0) || (cmd_dst_size == '0)) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else begin
                     state      <= S_ADDR_DATA;
                     beat_start <= 1'b1;
                  end
               end
            end
            S_ADDR_DATA: begin
               if (beat_req_done) begin
                  state <= S_RESP;
               end
            end
            S_RESP: begin
               if (beat_done) begin
                  if (beat_resp != AXI_RESP_OKAY) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else if (step == LAST_STEP) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     step       <= step + 3'd1;
                     beat_start <= 1'b1;
                     state      <= S_ADDR_DATA;
                  end
               end
            end
            S_DONE: begin
               state     <= S_IDLE;
               cmd_ready <= 1'b1;
            end
            default: begin
               state     <= S_IDLE;
               cmd_ready <= 1'b1;
            end
         endcase
      end
   end

   axil_wr_beat #(
      .ADDR_WIDTH (GLOB_ADDR_WIDTH),
      .DATA_WIDTH (GLOB_DATA_WIDTH)
   ) u_beat (
      .clk      (clk),
      .reset    (reset),
      .start    (beat_start),
      .addr     (wr_addr),
      .data     (wr_data),
      .req_done (beat_req_done),
      .done     (beat_done),
      .resp     (beat_resp),
      .awaddr   (M_AXI_AWADDR),
      .awvalid  (M_AXI_AWVALID),
      .awready  (M_AXI_AWREADY),
      .wdata    (M_AXI_WDATA),
      .wstrb    (M_AXI_WSTRB),
      .wvalid   (M_AXI_WVALID),
      .wready   (M_AXI_WREADY),
      .bresp    (M_AXI_BRESP),
      .bvalid   (M_AXI_BVALID),
      .bready   (M_AXI_BREADY)
   );

endmodule

// File: tb/tb_m_axi_dma_cfg_write.sv
// Bench for the DMA configuration write engine: table of descriptors run against
// an AXI4-Lite slave model, with writes and done pulses checked from queues.
module tb_m_axi_dma_cfg_write;

   localparam logic [31:0] BASE = 32'h4040_0000;

   typedef struct {
      logic [31:0] src_addr;
      logic [25:0] src_size;
      logic [31:0] dst_addr;
      logic [25:0] dst_size;
      int          aw_delay;
      int          w_delay;
      int          err_step;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic err;
      int   lat;
   } done_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_src_addr = '0;
   logic [25:0] cmd_src_size = '0;
   logic [31:0] cmd_dst_addr = '0;
   logic [25:0] cmd_dst_size = '0;
   logic        done;
   logic        err;
   logic [31:0] m_axi_awaddr;
   logic        m_axi_awvalid;
   logic        m_axi_awready = 1'b0;
   logic [31:0] m_axi_wdata;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_wvalid;
   logic        m_axi_wready = 1'b0;
   logic [1:0]  m_axi_bresp = 2'b00;
   logic        m_axi_bvalid = 1'b0;
   logic        m_axi_bready;

   int n_checks = 0;
   int n_pass = 0;

   wr_t   exp_wr[$];
   done_t exp_done[$];
   vec_t  vectors[9];

   int aw_delay = 0;
   int w_delay = 0;
   int err_step = -1;
   int wr_idx = 0;

   int          aw_wait = 0;
   int          w_wait = 0;
   logic        aw_got = 1'b0;
   logic        w_got = 1'b0;
   logic        resp_due = 1'b0;
   logic        b_fire = 1'b0;
   logic        aw_hold = 1'b0;
   logic        w_hold = 1'b0;
   logic [31:0] aw_hold_addr = '0;
   logic [31:0] w_hold_data = '0;
   logic [31:0] cap_addr = '0;
   logic [31:0] cap_data = '0;
   int          cyc = 0;

   m_axi_dma_cfg_write #(
      .DMA_BASE_ADDR (BASE)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_src_addr  (cmd_src_addr),
      .cmd_src_size  (cmd_src_size),
      .cmd_dst_addr  (cmd_dst_addr),
      .cmd_dst_size  (cmd_dst_size),
      .done          (done),
      .err           (err),
      .M_AXI_AWADDR  (m_axi_awaddr),
      .M_AXI_AWVALID (m_axi_awvalid),
      .M_AXI_AWREADY (m_axi_awready),
      .M_AXI_WDATA   (m_axi_wdata),
      .M_AXI_WSTRB   (m_axi_wstrb),
      .M_AXI_WVALID  (m_axi_wvalid),
      .M_AXI_WREADY  (m_axi_wready),
      .M_AXI_BRESP   (m_axi_bresp),
      .M_AXI_BVALID  (m_axi_bvalid),
      .M_AXI_BREADY  (m_axi_bready)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Slave model and done monitor; runs on the falling edge so it never races the DUT
   always @(negedge clk) begin
      if (reset) begin
         m_axi_awready = 1'b0;
         m_axi_wready  = 1'b0;
         m_axi_bvalid  = 1'b0;
         m_axi_bresp   = 2'b00;
         aw_got = 1'b0;
         w_got = 1'b0;
         resp_due = 1'b0;
         b_fire = 1'b0;
         aw_wait = 0;
         w_wait = 0;
         aw_hold = 1'b0;
         w_hold = 1'b0;
      end else begin
         cyc++;
         if (b_fire) begin
            m_axi_bvalid = 1'b0;
            b_fire = 1'b0;
         end
         if (resp_due) begin
            wr_t e;
            resp_due = 1'b0;
            m_axi_bvalid = 1'b1;
            m_axi_bresp = (wr_idx == err_step) ? 2'b10 : 2'b00;
            wr_idx++;
            check_output("write_expected", 64'(exp_wr.size() != 0), 64'd1);
            if (exp_wr.size() != 0) begin
               e = exp_wr.pop_front();
               check_output("write_addr", 64'(cap_addr), 64'(e.addr));
               check_output("write_data", 64'(cap_data), 64'(e.data));
            end
         end
         if (m_axi_bvalid && m_axi_bready) begin
            b_fire = 1'b1;
         end

         if (aw_hold) begin
            check_output("awvalid_held", 64'(m_axi_awvalid), 64'd1);
            check_output("awaddr_stable", 64'(m_axi_awaddr), 64'(aw_hold_addr));
         end
         if (w_hold) begin
            check_output("wvalid_held", 64'(m_axi_wvalid), 64'd1);
            check_output("wdata_stable", 64'(m_axi_wdata), 64'(w_hold_data));
         end

         if (m_axi_awvalid && !aw_got) begin
            m_axi_awready = (aw_wait >= aw_delay);
            aw_wait++;
         end else begin
            m_axi_awready = 1'b0;
         end
         if (m_axi_wvalid && !w_got) begin
            m_axi_wready = (w_wait >= w_delay);
            w_wait++;
         end else begin
            m_axi_wready = 1'b0;
         end
         aw_hold = m_axi_awvalid && !m_axi_awready;
         aw_hold_addr = m_axi_awaddr;
         w_hold = m_axi_wvalid && !m_axi_wready;
         w_hold_data = m_axi_wdata;
         if (m_axi_awvalid && m_axi_awready) begin
            aw_got = 1'b1;
            cap_addr = m_axi_awaddr;
         end
         if (m_axi_wvalid && m_axi_wready) begin
            w_got = 1'b1;
            cap_data = m_axi_wdata;
            check_output("wstrb_all_ones", 64'(m_axi_wstrb), 64'hF);
         end
         if (aw_got && w_got) begin
            resp_due = 1'b1;
            aw_got = 1'b0;
            w_got = 1'b0;
            aw_wait = 0;
            w_wait = 0;
         end

         if (done) begin
            done_t d;
            check_output("done_expected", 64'(exp_done.size() != 0), 64'd1);
            if (exp_done.size() != 0) begin
               d = exp_done.pop_front();
               check_output("done_err", 64'(err), 64'(d.err));
               if (d.lat != 0) begin
                  check_output("done_latency", 64'(cyc), 64'(d.lat));
               end
            end
         end
         if (cmd_valid && cmd_ready) begin
            cyc = 0;
         end
      end
   end

   task automatic push_expect(input vec_t v);
      wr_t   w [6];
      done_t d;
      int    last;
      w[0] = '{BASE + 32'h00, 32'h1};
      w[1] = '{BASE + 32'h30, 32'h1};
      w[2] = '{BASE + 32'h18, v.src_addr};
      w[3] = '{BASE + 32'h48, v.dst_addr};
      w[4] = '{BASE + 32'h58, {6'd0, v.dst_size}};
      w[5] = '{BASE + 32'h28, {6'd0, v.src_size}};
      if ((v.src_size == 26'd0) || (v.dst_size == 26'd0)) begin
         last = -1;
      end else if (v.err_step >= 0) begin
         last = v.err_step;
      end else begin
         last = 5;
      end
      for (int k = 0; k <= last; k++) begin
         exp_wr.push_back(w[k]);
      end
      d.err = v.exp_err;
      d.lat = v.exp_lat;
      exp_done.push_back(d);
   endtask

   task automatic drive_fields(input vec_t v);
      cmd_src_addr = v.src_addr;
      cmd_src_size = v.src_size;
      cmd_dst_addr = v.dst_addr;
      cmd_dst_size = v.dst_size;
   endtask

   task automatic wait_accept(input string name);
      logic accepted;
      accepted = 1'b0;
      for (int i = 0; i < 200 && !accepted; i++) begin
         accepted = cmd_ready;
         @(posedge clk);
         #1;
      end
      check_output(name, 64'(accepted), 64'd1);
   endtask

   task automatic wait_done(input int target, input string name);
      for (int i = 0; i < 400 && exp_done.size() > target; i++) begin
         @(posedge clk);
         #1;
      end
      check_output(name, 64'(exp_done.size()), 64'(target));
   endtask

   task automatic apply_stimulus(input vec_t v);
      aw_delay = v.aw_delay;
      w_delay = v.w_delay;
      err_step = v.err_step;
      wr_idx = 0;
      push_expect(v);
      drive_fields(v);
      cmd_valid = 1'b1;
      wait_accept("accept");
      cmd_valid = 1'b0;
      wait_done(0, "done_seen");
      check_output("writes_drained", 64'(exp_wr.size()), 64'd0);
      check_output("ready_after_done", 64'(cmd_ready), 64'd1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Reset while step 3 has its address valid up; the engine must drop everything and restart cleanly
   task automatic reset_mid_op();
      vec_t v;
      logic reached;
      v = '{32'hA000_0000, 26'h40, 32'hB000_0000, 26'h40, 8, 8, -1, 1'b0, 0};
      aw_delay = v.aw_delay;
      w_delay = v.w_delay;
      err_step = -1;
      wr_idx = 0;
      push_expect(v);
      drive_fields(v);
      cmd_valid = 1'b1;
      wait_accept("reset_op_accept");
      cmd_valid = 1'b0;
      reached = 1'b0;
      for (int i = 0; i < 200 && !reached; i++) begin
         if (wr_idx == 3 && m_axi_awvalid) begin
            reached = 1'b1;
         end else begin
            @(posedge clk);
            #1;
         end
      end
      check_output("reset_reached_step3", 64'(reached), 64'd1);
      exp_wr.delete();
      exp_done.delete();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_output("rst_mid_awvalid", 64'(m_axi_awvalid), 64'd0);
      check_output("rst_mid_wvalid", 64'(m_axi_wvalid), 64'd0);
      check_output("rst_mid_bready", 64'(m_axi_bready), 64'd0);
      check_output("rst_mid_cmd_ready", 64'(cmd_ready), 64'd1);
      check_output("rst_mid_done", 64'(done), 64'd0);
      apply_stimulus(vectors[0]);
   endtask

   // Two descriptors with cmd_valid held high; the second must wait for the first done
   task automatic back_to_back();
      vec_t a;
      vec_t b;
      logic ready_seen;
      a = '{32'h1111_0000, 26'h200, 32'h2222_0000, 26'h300, 0, 0, -1, 1'b0, 19};
      b = '{32'h3333_0000, 26'h010, 32'h4444_0000, 26'h020, 0, 0, -1, 1'b0, 19};
      aw_delay = 0;
      w_delay = 0;
      err_step = -1;
      wr_idx = 0;
      push_expect(a);
      push_expect(b);
      drive_fields(a);
      cmd_valid = 1'b1;
      wait_accept("b2b_accept_a");
      drive_fields(b);
      ready_seen = 1'b0;
      for (int i = 0; i < 400 && exp_done.size() == 2; i++) begin
         @(posedge clk);
         #1;
         if (exp_done.size() == 2) begin
            ready_seen = ready_seen | cmd_ready;
         end
      end
      check_output("b2b_ready_low_during_a", 64'(ready_seen), 64'd0);
      wait_accept("b2b_accept_b");
      cmd_valid = 1'b0;
      wait_done(0, "b2b_done_b");
      check_output("b2b_writes_drained", 64'(exp_wr.size()), 64'd0);
   endtask

   // Main sequence: reset state, descriptor table, then the multi-cycle corner cases
   initial begin
      vectors[0] = '{32'h1000_0000, 26'h100,     32'h2000_0000, 26'h100, 0, 0, -1, 1'b0, 19};
      vectors[1] = '{32'h1234_5670, 26'h3FF_FFFF, 32'h8765_4320, 26'h001, 3, 0, -1, 1'b0, 37};
      vectors[2] = '{32'h0000_0004, 26'h040,     32'hFFFF_FFFC, 26'h080, 0, 3, -1, 1'b0, 37};
      vectors[3] = '{32'h1000_0000, 26'h100,     32'h2000_0000, 26'h100, 0, 0,  2, 1'b1, 10};
      vectors[4] = '{32'h5000_0000, 26'h000,     32'h6000_0000, 26'h100, 0, 0, -1, 1'b1, 1};
      vectors[5] = '{32'h5000_0000, 26'h100,     32'h6000_0000, 26'h000, 0, 0, -1, 1'b1, 1};
      vectors[6] = '{32'hDEAD_BEE0, 26'h1234,    32'hCAFE_F000, 26'h5678, 1, 2, -1, 1'b0, 31};
      vectors[7] = '{32'h0BAD_0000, 26'h010,     32'h0FAD_0000, 26'h010, 0, 0,  0, 1'b1, 4};
      vectors[8] = '{32'h0ACE_0000, 26'h020,     32'h0BCE_0000, 26'h030, 0, 0,  5, 1'b1, 19};

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_output("reset_cmd_ready", 64'(cmd_ready), 64'd1);
      check_output("reset_awvalid", 64'(m_axi_awvalid), 64'd0);
      check_output("reset_wvalid", 64'(m_axi_wvalid), 64'd0);
      check_output("reset_bready", 64'(m_axi_bready), 64'd0);
      check_output("reset_done", 64'(done), 64'd0);
      check_output("reset_err", 64'(err), 64'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 9; i++) begin
         apply_stimulus(vectors[i]);
      end

      reset_mid_op();
      back_to_back();

      $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
